ram_1p_req_adapter: RTL and testbench

//  Host-side front end for the synchronous single-port RAM primitive (1-cycle read latency).

---
 rtl/ram_1p_req_adapter.sv | 116 +++++++++++
 tb/tb_ram_1p_req_adapter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_1p_req_adapter.sv
// Host req/gnt front end for a 1-cycle-latency single-port RAM. Returns one in-order
// response per accepted request and buffers read data under response backpressure.
module ram_1p_req_adapter #(
   parameter int unsigned Width       = 32,
   parameter int unsigned Depth       = 128,
   parameter int unsigned Outstanding = 2,
   localparam int unsigned Aw         = $clog2(Depth)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_i,
   output logic               gnt_o,
   input  logic               we_i,
   input  logic [Aw-1:0]      addr_i,
   input  logic [Width-1:0]   wdata_i,
   input  logic [Width/8-1:0] be_i,
   output logic               rvalid_o,
   input  logic               rready_i,
   output logic [Width-1:0]   rdata_o,
   output logic               rerr_o,
   output logic               ram_req_o,
   output logic               ram_write_o,
   output logic [Aw-1:0]      ram_addr_o,
   output logic [Width-1:0]   ram_wdata_o,
   output logic [Width-1:0]   ram_wmask_o,
   input  logic [Width-1:0]   ram_rdata_i
);

   localparam int unsigned PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
   localparam int unsigned CntW = $clog2(Outstanding + 1);
   localparam logic [Aw:0] DepthW = (Aw + 1)'(Depth);
   localparam logic [CntW:0] MaxInflight = (CntW + 1)'(Outstanding);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Outstanding - 1);

   logic              stage_valid_q, stage_read_q, stage_err_q;
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic [Width:0]    fifo_q [Outstanding];
   logic [Width:0]    head;
   logic [Width-1:0]  stage_data;
   logic [CntW:0]     inflight;
   logic              in_range, accept, fifo_empty, push, pop;

   assign in_range = {1'b0, addr_i} < DepthW;
   assign inflight = (CntW + 1)'(stage_valid_q) + (CntW + 1)'(count_q);
   // Credits come only from registered state, so rready_i never reaches gnt_o combinationally.
   assign gnt_o    = inflight < MaxInflight;
   assign accept   = req_i && gnt_o;

   assign ram_req_o   = accept && in_range;
   assign ram_write_o = we_i;
   assign ram_addr_o  = addr_i;
   assign ram_wdata_o = wdata_i;

   for (genvar i = 0; i < Width; i++) begin : g_wmask
      assign ram_wmask_o[i] = be_i[i/8];
   end

   assign stage_data = (stage_read_q && !stage_err_q) ? ram_rdata_i : '0;
   assign fifo_empty = (count_q == '0);
   assign head       = fifo_q[rd_ptr_q];

   always_comb begin
      rvalid_o = 1'b0;
      rdata_o  = '0;
      rerr_o   = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      if (!fifo_empty) begin
         rvalid_o = 1'b1;
         rdata_o  = head[Width-1:0];
         rerr_o   = head[Width];
         pop      = rready_i;
         push     = stage_valid_q;
      end else if (stage_valid_q) begin
         // Stage bypasses the FIFO; it is only captured if not consumed now.
         rvalid_o = 1'b1;
         rdata_o  = stage_data;
         rerr_o   = stage_err_q;
         push     = !rready_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stage_valid_q <= 1'b0;
         stage_read_q  <= 1'b0;
         stage_err_q   <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         stage_valid_q <= accept;
         stage_read_q  <= accept && !we_i;
         stage_err_q   <= accept && !in_range;
         if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= {stage_err_q, stage_data};
   end

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      push && !pop |-> count_q < CntW'(Outstanding));

   a_inflight : assert property (@(posedge clk_i) disable iff (rst_i)
      inflight <= MaxInflight);

   a_resp_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      rvalid_o && !rready_i |=> $stable(rvalid_o) && $stable(rdata_o) && $stable(rerr_o));

endmodule

// File: tb/tb_ram_1p_req_adapter.sv
// Directed bench for ram_1p_req_adapter: vector table for single transactions plus
// sequences for backpressure, streaming and mid-operation reset.
module tb_ram_1p_req_adapter;

   localparam int Width = 32;
   localparam int Depth = 100;
   localparam int Aw    = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic              req, gnt, we, rvalid, rready, rerr;
   logic [Aw-1:0]     addr;
   logic [Width-1:0]  wdata, rdata;
   logic [3:0]        be;
   logic              ram_req, ram_write;
   logic [Aw-1:0]     ram_addr;
   logic [Width-1:0]  ram_wdata, ram_wmask, ram_rdata;

   logic [Width-1:0]  mem [Depth];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ram_1p_req_adapter #(.Width(Width), .Depth(Depth), .Outstanding(2)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
      .rerr_o(rerr), .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata)
   );

   // Behavioural single-port RAM, 1-cycle read latency.
   always @(posedge clk) begin
      if (ram_req) begin
         if (ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
         else           ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [Aw-1:0] a, input logic [31:0] d,
                        input logic [3:0] b);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
   endtask

   typedef struct {
      logic          we;
      logic [Aw-1:0] addr;
      logic [31:0]   wdata;
      logic [3:0]    be;
      logic          exp_ram_req;
      logic [31:0]   exp_wmask;
      logic [31:0]   exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vecs[10];
   logic [31:0] exp_q[$];

   initial begin
      vecs[0] = '{1'b1, 7'd5,   32'hDEADBEEF, 4'hF, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[1] = '{1'b0, 7'd5,   32'h0,        4'h0, 1'b1, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2] = '{1'b1, 7'd5,   32'hAABBCCDD, 4'h5, 1'b1, 32'h00FF00FF, 32'h0,        1'b0};
      vecs[3] = '{1'b0, 7'd5,   32'h0,        4'h0, 1'b1, 32'h0,        32'hDEBBBEDD, 1'b0};
      vecs[4] = '{1'b0, 7'd100, 32'h0,        4'h0, 1'b0, 32'h0,        32'h0,        1'b1};
      vecs[5] = '{1'b0, 7'd99,  32'h0,        4'h0, 1'b1, 32'h0,        32'h10000063, 1'b0};
      vecs[6] = '{1'b1, 7'd100, 32'h55555555, 4'hF, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[7] = '{1'b1, 7'd99,  32'h12345678, 4'hF, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[8] = '{1'b0, 7'd99,  32'h0,        4'h0, 1'b1, 32'h0,        32'h12345678, 1'b0};
      vecs[9] = '{1'b0, 7'd127, 32'h0,        4'h0, 1'b0, 32'h0,        32'h0,        1'b1};

      for (int i = 0; i < Depth; i++) mem[i] = 32'h1000_0000 + i;
      ram_rdata = '0;
      req = 0; we = 0; addr = '0; wdata = '0; be = '0; rready = 1'b1;

      // Reset state
      rst = 1'b1;
      #1;
      chk("reset gnt", 32'(gnt), 1);
      chk("reset rvalid", 32'(rvalid), 0);
      chk("reset rdata", rdata, 0);
      chk("reset rerr", 32'(rerr), 0);
      chk("reset ram_req", 32'(ram_req), 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Single transactions from the table
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         #1;
         chk($sformatf("v%0d gnt", i), 32'(gnt), 1);
         chk($sformatf("v%0d ram_req", i), 32'(ram_req), 32'(vecs[i].exp_ram_req));
         chk($sformatf("v%0d wmask", i), ram_wmask, vecs[i].exp_wmask);
         tick();
         req = 1'b0;
         chk($sformatf("v%0d rvalid", i), 32'(rvalid), 1);
         chk($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("v%0d rerr", i), 32'(rerr), 32'(vecs[i].exp_err));
      end
      tick();
      chk("idle rvalid", 32'(rvalid), 0);

      // Backpressure: two grants, third blocked, in-order release
      rready = 1'b0;
      drive(1'b0, 7'd1, '0, '0);
      #1 chk("bp gnt1", 32'(gnt), 1);
      tick();
      drive(1'b0, 7'd2, '0, '0);
      chk("bp gnt2", 32'(gnt), 1);
      chk("bp stage rvalid", 32'(rvalid), 1);
      chk("bp stage rdata", rdata, 32'h10000001);
      tick();
      drive(1'b0, 7'd3, '0, '0);
      chk("bp gnt3 low", 32'(gnt), 0);
      chk("bp blocked ram_req", 32'(ram_req), 0);
      tick();
      req = 1'b0;
      chk("bp gnt still low", 32'(gnt), 0);
      chk("bp head held", rdata, 32'h10000001);
      rready = 1'b1;
      #1 chk("bp no comb release", 32'(gnt), 0);
      tick();
      chk("bp gnt after pop", 32'(gnt), 1);
      chk("bp second rvalid", 32'(rvalid), 1);
      chk("bp second rdata", rdata, 32'h10000002);
      tick();
      chk("bp drained", 32'(rvalid), 0);

      // Streaming: alternate writes and reads, one response per cycle
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) begin
            chk($sformatf("st%0d rvalid", k), 32'(rvalid), 1);
            chk($sformatf("st%0d rdata", k), rdata, exp_q.pop_front());
         end
         if (k < 16) begin
            if (k % 2 == 0) begin
               drive(1'b1, 7'(40 + k), 32'(k * 3), 4'hF);
               exp_q.push_back(32'h0);
            end else begin
               drive(1'b0, 7'(20 + k), '0, '0);
               exp_q.push_back(32'h1000_0000 + 32'(20 + k));
            end
            #1 chk($sformatf("st%0d gnt", k), 32'(gnt), 1);
            @(posedge clk);
            #1;
         end else begin
            req = 1'b0;
         end
      end
      tick();
      chk("st idle", 32'(rvalid), 0);

      // Mid-operation reset with two responses pending
      rready = 1'b0;
      drive(1'b0, 7'd1, '0, '0);
      tick();
      drive(1'b0, 7'd2, '0, '0);
      tick();
      req = 1'b0;
      chk("rst pre rvalid", 32'(rvalid), 1);
      chk("rst pre gnt", 32'(gnt), 0);
      #2 rst = 1'b1;
      #1;
      chk("rst rvalid", 32'(rvalid), 0);
      chk("rst gnt", 32'(gnt), 1);
      chk("rst rdata", rdata, 0);
      tick();
      rst = 1'b0;
      rready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("rst stale %0d", c), 32'(rvalid), 0);
      end
      drive(1'b0, 7'd5, '0, '0);
      tick();
      req = 1'b0;
      chk("rst ram kept", rdata, 32'hDEBBBEDD);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
